// File: rtl/aftab_dbgregaccess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aftab_dbgregaccess_pkg
// Description : Shared types, FSM states and error codes for debug GPR access.
// Revision    : 1.0 - initial release
// ============================================================================
package aftab_dbgregaccess_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_RD_OUT    = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_WR_COMMIT = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_HALT  = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_LOST  = 2'b11;

  // True when the burst would run past x31; the sum is taken 6 bits wide.
  function automatic logic range_bad(input logic [4:0] regno, input logic [4:0] count);
    logic [5:0] sum;
    sum = {1'b0, regno} + {1'b0, count};
    return sum > 6'd31;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aftab_dbgregaccess_if.sv
`default_nettype none
// ============================================================================
// Module      : aftab_dbgregaccess_if
// Description : Debug command/data handshakes plus register-file port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface aftab_dbgregaccess_if
  import aftab_dbgregaccess_pkg::*;
#(
  parameter int SIZE = DATA_W
);
  logic            halted;
  logic            cmdValid;
  logic            cmdReady;
  logic            cmdWrite;
  logic [4:0]      cmdRegno;
  logic [4:0]      cmdCount;
  logic [SIZE-1:0] dataIn;
  logic            dataInValid;
  logic            dataInReady;
  logic [SIZE-1:0] dataOut;
  logic            dataOutValid;
  logic            dataOutReady;
  logic            busy;
  logic [1:0]      err;
  logic            errClr;
  logic [4:0]      rs1;
  logic [SIZE-1:0] p1;
  logic [4:0]      rd;
  logic [SIZE-1:0] writeData;
  logic            writeRegFile;

  modport master (
    output halted, cmdValid, cmdWrite, cmdRegno, cmdCount, dataIn, dataInValid,
           dataOutReady, errClr, p1,
    input  cmdReady, dataInReady, dataOut, dataOutValid, busy, err, rs1, rd,
           writeData, writeRegFile
  );

  modport slave (
    input  halted, cmdValid, cmdWrite, cmdRegno, cmdCount, dataIn, dataInValid,
           dataOutReady, errClr, p1,
    output cmdReady, dataInReady, dataOut, dataOutValid, busy, err, rs1, rd,
           writeData, writeRegFile
  );

endinterface
`default_nettype wire

// File: rtl/aftab_dbgregaccess.sv
`default_nettype none
// ============================================================================
// Module      : aftab_dbgregaccess
// Description : Turns debugger register commands into GPR read/write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module aftab_dbgregaccess
  import aftab_dbgregaccess_pkg::*;
#(
  parameter int SIZE = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  aftab_dbgregaccess_if.slave bus
);

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      rem_q, rem_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rd_q, rd_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic [SIZE-1:0] dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic [1:0]      err_q, err_d;

  logic            cmd_ready_w;
  logic            din_ready_w;
  logic            wr_strobe_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      rs1_q    <= rs1_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    rs1_d       = rs1_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    dvalid_d    = dvalid_q;
    err_d       = err_q;
    cmd_ready_w = 1'b0;
    din_ready_w = 1'b0;
    wr_strobe_w = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_w = (err_q == ERR_NONE);
        if (bus.errClr) begin
          err_d = ERR_NONE;
        end
        // Error assignments come after the clear so a fresh error wins.
        if (bus.cmdValid && cmd_ready_w) begin
          if (!bus.halted) begin
            err_d = ERR_HALT;
          end else if (range_bad(bus.cmdRegno, bus.cmdCount)) begin
            err_d = ERR_RANGE;
          end else begin
            idx_d   = bus.cmdRegno;
            rem_d   = bus.cmdCount;
            rs1_d   = bus.cmdRegno;
            state_d = bus.cmdWrite ? ST_WR_WAIT : ST_RD;
          end
        end
      end
      ST_RD: begin
        dout_d   = bus.p1;
        dvalid_d = 1'b1;
        state_d  = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (bus.dataOutReady) begin
          dvalid_d = 1'b0;
          if (rem_q == 5'd0) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            rs1_d   = idx_q + 5'd1;
            rem_d   = rem_q - 5'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_WR_WAIT: begin
        din_ready_w = 1'b1;
        if (bus.dataInValid) begin
          rd_d    = idx_q;
          wdata_d = bus.dataIn;
          state_d = ST_WR_COMMIT;
        end
      end
      ST_WR_COMMIT: begin
        wr_strobe_w = 1'b1;
        if (rem_q == 5'd0) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 5'd1;
          rem_d   = rem_q - 5'd1;
          state_d = ST_WR_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Losing halt mid-command aborts: no strobe, pending read word dropped.
    if ((state_q != ST_IDLE) && !bus.halted) begin
      state_d     = ST_IDLE;
      dvalid_d    = 1'b0;
      err_d       = ERR_LOST;
      wr_strobe_w = 1'b0;
    end
  end

  assign bus.cmdReady     = cmd_ready_w;
  assign bus.dataInReady  = din_ready_w;
  assign bus.dataOut      = dout_q;
  assign bus.dataOutValid = dvalid_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.err          = err_q;
  assign bus.rs1          = rs1_q;
  assign bus.rd           = rd_q;
  assign bus.writeData    = wdata_q;
  assign bus.writeRegFile = wr_strobe_w;

endmodule
`default_nettype wire

// File: tb/tb_aftab_dbgregaccess.sv
`default_nettype none
// ============================================================================
// Module      : tb_aftab_dbgregaccess
// Description : Directed self-checking bench for the debug GPR access engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aftab_dbgregaccess;

  logic clk;
  logic rst;

  aftab_dbgregaccess_if #(.SIZE(32)) bus();

  aftab_dbgregaccess #(.SIZE(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];

  function automatic logic [31:0] rf_init(input int i);
    case (i)
      0:       return 32'h0;
      5:       return 32'h0000_00A5;
      6:       return 32'h0000_00B6;
      7:       return 32'h0000_00C7;
      default: return 32'h1000_0000 + i;
    endcase
  endfunction

  // Register file model: x0 hard-wired to zero, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
    end else if (bus.writeRegFile && (bus.rd != 5'd0)) begin
      rf[bus.rd] <= bus.writeData;
    end
  end

  assign bus.p1 = (bus.rs1 == 5'd0) ? 32'h0 : rf[bus.rs1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] got_words[$];
  int          got_cyc[$];
  int          busy_cycles;
  int          strobes;
  int          hs;

  // Issue a read burst with dataOutReady tied high; cycles counted from accept.
  task automatic run_read(input logic [4:0] regno, input logic [4:0] cnt);
    got_words.delete();
    got_cyc.delete();
    busy_cycles       = 0;
    bus.cmdValid      = 1'b1;
    bus.cmdWrite      = 1'b0;
    bus.cmdRegno      = regno;
    bus.cmdCount      = cnt;
    bus.dataOutReady  = 1'b1;
    tick();
    bus.cmdValid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (bus.dataOutValid) begin
        got_words.push_back(bus.dataOut);
        got_cyc.push_back(c);
      end
      if (!bus.busy) break;
      busy_cycles++;
      tick();
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.halted       = 1'b1;
    bus.cmdValid     = 1'b0;
    bus.cmdWrite     = 1'b0;
    bus.cmdRegno     = '0;
    bus.cmdCount     = '0;
    bus.dataIn       = '0;
    bus.dataInValid  = 1'b0;
    bus.dataOutReady = 1'b0;
    bus.errClr       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_cmdReady",     32'(bus.cmdReady),     32'd1);
    check("rst_dataInReady",  32'(bus.dataInReady),  32'd0);
    check("rst_dataOutValid", 32'(bus.dataOutValid), 32'd0);
    check("rst_dataOut",      bus.dataOut,           32'd0);
    check("rst_busy",         32'(bus.busy),         32'd0);
    check("rst_err",          32'(bus.err),          32'd0);
    check("rst_rs1",          32'(bus.rs1),          32'd0);
    check("rst_rd",           32'(bus.rd),           32'd0);
    check("rst_writeData",    bus.writeData,         32'd0);
    check("rst_writeRegFile", 32'(bus.writeRegFile), 32'd0);

    // Read x5..x7
    run_read(5'd5, 5'd2);
    check("rd3_nwords", 32'(got_words.size()), 32'd3);
    if (got_words.size() == 3) begin
      check("rd3_w0", got_words[0], 32'h0000_00A5);
      check("rd3_w1", got_words[1], 32'h0000_00B6);
      check("rd3_w2", got_words[2], 32'h0000_00C7);
      check("rd3_c0", 32'(got_cyc[0]), 32'd2);
      check("rd3_c1", 32'(got_cyc[1]), 32'd4);
      check("rd3_c2", 32'(got_cyc[2]), 32'd6);
    end
    check("rd3_busy_cycles", 32'(busy_cycles), 32'd6);
    check("rd3_err", 32'(bus.err), 32'd0);

    // x0 reads as zero with no error, then x1
    run_read(5'd0, 5'd1);
    check("rdx0_nwords", 32'(got_words.size()), 32'd2);
    if (got_words.size() == 2) begin
      check("rdx0_w0", got_words[0], 32'h0);
      check("rdx0_w1", got_words[1], 32'h1000_0001);
    end
    check("rdx0_err", 32'(bus.err), 32'd0);

    // Single write to x31
    bus.cmdValid = 1'b1;
    bus.cmdWrite = 1'b1;
    bus.cmdRegno = 5'd31;
    bus.cmdCount = 5'd0;
    tick();
    bus.cmdValid = 1'b0;
    check("wr_dataInReady", 32'(bus.dataInReady), 32'd1);
    check("wr_busy", 32'(bus.busy), 32'd1);
    bus.dataIn      = 32'hDEAD_BEEF;
    bus.dataInValid = 1'b1;
    check("wr_strobe_early", 32'(bus.writeRegFile), 32'd0);
    tick();
    bus.dataInValid = 1'b0;
    check("wr_strobe", 32'(bus.writeRegFile), 32'd1);
    check("wr_rd", 32'(bus.rd), 32'd31);
    check("wr_writeData", bus.writeData, 32'hDEAD_BEEF);
    check("wr_dataInReady_commit", 32'(bus.dataInReady), 32'd0);
    tick();
    check("wr_strobe_after", 32'(bus.writeRegFile), 32'd0);
    check("wr_busy_after", 32'(bus.busy), 32'd0);
    check("wr_rf31", rf[31], 32'hDEAD_BEEF);

    // Command while not halted
    bus.halted   = 1'b0;
    bus.cmdValid = 1'b1;
    bus.cmdWrite = 1'b0;
    bus.cmdRegno = 5'd1;
    bus.cmdCount = 5'd0;
    tick();
    bus.cmdValid = 1'b0;
    check("nh_err", 32'(bus.err), 32'd1);
    check("nh_busy", 32'(bus.busy), 32'd0);
    check("nh_cmdReady", 32'(bus.cmdReady), 32'd0);
    tick();
    check("nh_busy2", 32'(bus.busy), 32'd0);
    bus.errClr = 1'b1;
    check("nh_cmdReady_clr", 32'(bus.cmdReady), 32'd0);
    tick();
    bus.errClr = 1'b0;
    bus.halted = 1'b1;
    check("nh_err_cleared", 32'(bus.err), 32'd0);
    check("nh_cmdReady_after", 32'(bus.cmdReady), 32'd1);

    // Out-of-range burst
    bus.cmdValid = 1'b1;
    bus.cmdWrite = 1'b1;
    bus.cmdRegno = 5'd30;
    bus.cmdCount = 5'd3;
    tick();
    bus.cmdValid = 1'b0;
    check("rg_err", 32'(bus.err), 32'd2);
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.writeRegFile || bus.dataOutValid || bus.busy) strobes++;
      tick();
    end
    check("rg_activity", 32'(strobes), 32'd0);
    check("rg_rs1", 32'(bus.rs1), 32'd31);
    bus.errClr = 1'b1;
    tick();
    bus.errClr = 1'b0;
    check("rg_err_cleared", 32'(bus.err), 32'd0);

    // 4-word write, halt lost after the second commit
    bus.cmdValid = 1'b1;
    bus.cmdWrite = 1'b1;
    bus.cmdRegno = 5'd10;
    bus.cmdCount = 5'd3;
    tick();
    bus.cmdValid    = 1'b0;
    bus.dataInValid = 1'b1;
    strobes = 0;
    hs      = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.writeRegFile) strobes++;
      if (c == 5) bus.halted = 1'b0;
      bus.dataIn = 32'hCAFE_0000 + hs;
      if (bus.dataInReady && bus.dataInValid) hs++;
      tick();
      if (c == 5) begin
        check("hl_err", 32'(bus.err), 32'd3);
        check("hl_busy", 32'(bus.busy), 32'd0);
        check("hl_dataInReady", 32'(bus.dataInReady), 32'd0);
      end
    end
    bus.dataInValid = 1'b0;
    check("hl_strobes", 32'(strobes), 32'd2);
    check("hl_rf10", rf[10], 32'hCAFE_0000);
    check("hl_rf11", rf[11], 32'hCAFE_0001);
    check("hl_rf12", rf[12], 32'h1000_000C);
    bus.halted = 1'b1;
    bus.errClr = 1'b1;
    tick();
    bus.errClr = 1'b0;

    // Reset during RD_OUT, then a fresh read
    bus.cmdValid     = 1'b1;
    bus.cmdWrite     = 1'b0;
    bus.cmdRegno     = 5'd7;
    bus.cmdCount     = 5'd1;
    bus.dataOutReady = 1'b0;
    tick();
    bus.cmdValid = 1'b0;
    tick();
    check("rr_valid", 32'(bus.dataOutValid), 32'd1);
    check("rr_data", bus.dataOut, 32'h0000_00C7);
    rst = 1'b1;
    tick();
    check("rr_dataOutValid", 32'(bus.dataOutValid), 32'd0);
    check("rr_dataOut", bus.dataOut, 32'd0);
    check("rr_busy", 32'(bus.busy), 32'd0);
    check("rr_rs1", 32'(bus.rs1), 32'd0);
    check("rr_err", 32'(bus.err), 32'd0);
    check("rr_cmdReady", 32'(bus.cmdReady), 32'd1);
    check("rr_writeRegFile", 32'(bus.writeRegFile), 32'd0);
    rst = 1'b0;
    tick();
    run_read(5'd6, 5'd0);
    check("rr2_nwords", 32'(got_words.size()), 32'd1);
    if (got_words.size() == 1) begin
      check("rr2_w0", got_words[0], 32'h0000_00B6);
      check("rr2_c0", 32'(got_cyc[0]), 32'd2);
    end
    check("rr2_busy_cycles", 32'(busy_cycles), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
